// File: rtl/multiplier.sv
// ---------------------------------------------------------------------------
// multiplier
// Sequential 10x10 unsigned shift-and-add multiplier. A start accepted in
// IDLE latches both operands, ten CALC cycles accumulate the 20-bit
// product, and the result is published with a one-cycle valid pulse.
//
// Ports
//   clk    in   1   system clock, rising-edge active
//   sclr   in   1   synchronous active-high clear, overrides all inputs
//   a_in   in  10   unsigned multiplicand, sampled when a start is accepted
//   b_in   in  10   unsigned multiplier, sampled when a start is accepted
//   start  in   1   level request, honoured only in IDLE
//   q_out  out 10   low 10 bits of the product (held until next result)
//   zro    out  1   full 20-bit product is zero
//   ovf    out  1   product bits [19:10] are nonzero
//   busy   out  1   multiplication in progress
//   valid  out  1   one-cycle pulse marking new q_out/zro/ovf
// ---------------------------------------------------------------------------
module multiplier (
    input  logic       clk,
    input  logic       sclr,
    input  logic [9:0] a_in,
    input  logic [9:0] b_in,
    input  logic       start,
    output logic [9:0] q_out,
    output logic       zro,
    output logic       ovf,
    output logic       busy,
    output logic       valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [19:0] mcand_q,  mcand_d;
    logic [9:0]  mplier_q, mplier_d;
    logic [19:0] acc_q,    acc_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [9:0]  q_out_q,  q_out_d;
    logic        zro_q,    zro_d;
    logic        ovf_q,    ovf_d;
    logic        busy_q,   busy_d;
    logic        valid_q,  valid_d;

    // Accumulator value after this cycle's conditional add.
    logic [19:0] acc_add_s;

    // Next-state and datapath logic for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        q_out_d  = q_out_q;
        zro_d    = zro_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        valid_d  = valid_q;

        if (mplier_q[0] == 1'b1) begin
            acc_add_s = acc_q + mcand_q;
        end else begin
            acc_add_s = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start == 1'b1) begin
                    mcand_d  = {10'd0, a_in};
                    mplier_d = b_in;
                    acc_d    = 20'd0;
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d    = acc_add_s;
                mcand_d  = {mcand_q[18:0], 1'b0};
                mplier_d = {1'b0, mplier_q[9:1]};
                cnt_d    = cnt_q + 4'd1;
                // Tenth iteration: publish the result including this add.
                if (cnt_q == 4'd9) begin
                    q_out_d = acc_add_s[9:0];
                    ovf_d   = |acc_add_s[19:10];
                    zro_d   = (acc_add_s == 20'd0);
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 20'd0;
            mplier_q <= 10'd0;
            acc_q    <= 20'd0;
            cnt_q    <= 4'd0;
            q_out_q  <= 10'd0;
            zro_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            q_out_q  <= q_out_d;
            zro_q    <= zro_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign q_out = q_out_q;
    assign zro   = zro_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_multiplier.sv
// ---------------------------------------------------------------------------
// tb_multiplier
// Self-checking bench for multiplier. A cycle-level reference model tracks
// when starts are accepted; each accepted operation pushes its expected
// result onto a scoreboard queue, which is popped when valid is seen.
// ---------------------------------------------------------------------------
module tb_multiplier;

    logic       clk;
    logic       sclr;
    logic [9:0] a_in;
    logic [9:0] b_in;
    logic       start;
    logic [9:0] q_out;
    logic       zro;
    logic       ovf;
    logic       busy;
    logic       valid;

    typedef struct {
        logic [9:0] q;
        logic       z;
        logic       o;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_pend;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    bit   chk_en  = 1'b0;
    logic [9:0] m_q = 10'd0;
    logic       m_z = 1'b0;
    logic       m_o = 1'b0;

    multiplier dut (
        .clk   (clk),
        .sclr  (sclr),
        .a_in  (a_in),
        .b_in  (b_in),
        .start (start),
        .q_out (q_out),
        .zro   (zro),
        .ovf   (ovf),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when it does not match.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: after edge Ek of an operation m_cnt = k+1; idle is 0.
    always @(posedge clk) begin
        if (sclr) begin
            if (m_cnt >= 1 && m_cnt <= 10 && sb_q.size() > 0)
                sb_q.delete(sb_q.size() - 1);
            m_cnt  = 0;
            m_q    = 10'd0;
            m_z    = 1'b0;
            m_o    = 1'b0;
            chk_en = 1'b1;
        end else if (m_cnt == 0) begin
            if (start) begin
                logic [19:0] p;
                p = {10'd0, a_in} * {10'd0, b_in};
                m_pend.q = p[9:0];
                m_pend.z = (p == 20'd0);
                m_pend.o = (p[19:10] != 10'd0);
                sb_q.push_back(m_pend);
                m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 11) begin
                m_q = m_pend.q;
                m_z = m_pend.z;
                m_o = m_pend.o;
            end
            if (m_cnt == 12) m_cnt = 0;
        end
    end

    // Monitor: compare DUT against the model each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("busy",  busy,  (m_cnt >= 1 && m_cnt <= 10));
            check_eq("valid", valid, (m_cnt == 11));
            check_eq("q_hold", q_out, m_q);
            check_eq("zro_hold", zro, m_z);
            check_eq("ovf_hold", ovf, m_o);
            if (valid) begin
                check_eq("sb_nonempty", (sb_q.size() > 0), 1'b1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_q_out", q_out, e.q);
                    check_eq("sb_zro",   zro,   e.z);
                    check_eq("sb_ovf",   ovf,   e.o);
                end
            end
        end
    end

    // One operation followed by enough idle cycles to return to IDLE.
    task automatic run_op(input logic [9:0] a, input logic [9:0] b, input int gap);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = 10'($urandom_range(0, 1023));
        b_in  = 10'($urandom_range(0, 1023));
        repeat (11 + gap) @(negedge clk);
    endtask

    initial begin
        sclr  = 1'b1;
        start = 1'b0;
        a_in  = 10'd0;
        b_in  = 10'd0;
        repeat (2) @(negedge clk);
        sclr = 1'b0;
        repeat (2) @(negedge clk);

        // basic, overflow and zero scenarios
        run_op(10'd25,   10'd4,    0);
        run_op(10'd1000, 10'd2,    1);
        run_op(10'd1023, 10'd1023, 0);
        run_op(10'd0,    10'd517,  2);
        run_op(10'd512,  10'd2,    0);

        // start while busy: a second start pulse at E4 is ignored
        start = 1'b1; a_in = 10'd3; b_in = 10'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a_in = 10'd7; b_in = 10'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        // operands change mid-op, start held: second accept at E12
        start = 1'b1; a_in = 10'd11; b_in = 10'd13;
        @(negedge clk);
        repeat (2) @(negedge clk);
        a_in = 10'd99; b_in = 10'd77;
        repeat (9) @(negedge clk);
        a_in = 10'd600; b_in = 10'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset mid-op at E5 aborts; then a fresh operation
        start = 1'b1; a_in = 10'd300; b_in = 10'd300;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        run_op(10'd824, 10'd1, 0);

        // reset in DONE: cleared outputs, no further pulse
        start = 1'b1; a_in = 10'd40; b_in = 10'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        repeat (2) @(negedge clk);

        // sclr with start: reset only, then start accepted next edge
        sclr = 1'b1; start = 1'b1; a_in = 10'd5; b_in = 10'd6;
        @(negedge clk);
        sclr = 1'b0;
        run_op(10'd17, 10'd19, 0);

        // random operations with random idle gaps
        for (int i = 0; i < 20; i++) begin
            run_op(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 3)));
        end

        repeat (14) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (clk, sclr); all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 sclr  input  1  synchronous active-high reset; it overrides all other inputs.
REQ-004 a_in  input  10  unsigned multiplicand, sampled only when a start is accepted.
REQ-005 b_in  input  10  unsigned multiplier, sampled only when a start is accepted.
REQ-006 start  input  1  level request, sampled on each rising edge.
REQ-007 q_out  output  10  registered product, low 10 bits of a_in*b_in.
REQ-008 zro  output  1  registered flag; 1 when the full 20-bit product is 0.
REQ-009 ovf  output  1  registered flag; 1 when product bits [19:10] are nonzero.
REQ-010 busy  output  1  registered; 1 while a multiplication is in progress.
REQ-011 valid  output  1  registered one-cycle pulse marking new q_out/zro/ovf.

Function
REQ-012 The FSM SHALL have three states (IDLE, CALC, DONE) and no other reachable state.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL:
- latch a_in into a 20-bit multiplicand register (zero-extended);
- latch b_in into a 10-bit multiplier register;
- clear the 20-bit accumulator and the 4-bit iteration counter;
- set busy=1 and enter CALC.
REQ-014 In IDLE with start=0, the block SHALL hold all registers and outputs.
REQ-015 On each CALC edge, the block SHALL:
- add the multiplicand register to the accumulator when the multiplier register LSB is 1;
- shift the multiplicand left 1 and the multiplier right 1 (logical);
- increment the counter.
REQ-016 CALC SHALL last exactly 10 edges (E1..E10), with the counter running 0..9; on E10 the FSM SHALL enter DONE.
REQ-017 On E10, the block SHALL write q_out=acc[9:0], ovf=|acc[19:10], zro=(acc==0), busy=0, valid=1, using the final accumulator value that includes the 10th add.
REQ-018 On the DONE edge E11, the block SHALL clear valid and return to IDLE.
- valid is high for exactly one cycle, between E10 and E11.
- start is ignored in DONE.
REQ-019 Latency from the accepting edge E0 to valid=1 SHALL be 10 clock cycles; at most one operation may start every 12 cycles.
REQ-020 busy SHALL be 1 from E0 through E10, i.e. for 10 cycles.
REQ-021 In CALC and DONE, start, a_in and b_in SHALL be ignored; changes to them SHALL NOT affect the result in progress.
REQ-022 If start is held high continuously, a new operation SHALL be accepted on the first edge in IDLE (E12), with operands sampled at that edge.
REQ-023 q_out, zro and ovf SHALL hold their last values until the next E10 or sclr; they SHALL NOT change at E0.
REQ-024 Arithmetic SHALL be unsigned and 20-bit internally, with no loss: 1023*1023=1046529 fits.

Reset
REQ-025 With sclr=1 at an edge, the block SHALL:
- set the state to IDLE;
- set q_out=0, zro=0, ovf=0, busy=0, valid=0;
- clear the accumulator, multiplicand, multiplier and counter.
REQ-026 sclr asserted mid-CALC or in DONE SHALL abort the operation; no valid pulse SHALL follow for the aborted operation.
REQ-027 sclr=1 together with start=1 SHALL reset only; start SHALL NOT be accepted on that edge.
REQ-028 After sclr is released, the first start SHALL be acceptable on the next edge.
REQ-029 Outputs are undefined before the first sclr; the bench SHALL apply sclr first.

Verification
REQ-030 Scenario "basic": sclr, then start with a_in=25, b_in=4 -> at E10 q_out=100, zro=0, ovf=0, valid=1 for one cycle; busy=1 for E0..E10.
REQ-031 Scenario "overflow": a_in=1000, b_in=2 -> q_out=976 (2000 mod 1024), ovf=1, zro=0; a_in=1023, b_in=1023 -> q_out=1 (1046529 mod 1024), ovf=1.
REQ-032 Scenario "zero": a_in=0, b_in=517 -> q_out=0, zro=1, ovf=0; a_in=1024-wrap not applicable; a_in=512, b_in=2 -> q_out=0, zro=0, ovf=1.
REQ-033 Scenario "start while busy": start a_in=3, b_in=5; pulse start with a_in=7, b_in=7 at E4 -> result is q_out=15; valid pulses once; no second operation starts.
REQ-034 Scenario "operands change": change a_in/b_in at E3 -> result still reflects the values latched at E0; hold start high -> second operation is accepted at E12, and its valid pulse occurs at E22.
REQ-035 Scenario "reset mid-op": sclr at E5 -> busy=0 and all outputs 0 on the next edge; no valid pulse; a new start then completes normally, e.g. 824*1 -> q_out=824, ovf=0.
